// File: rtl/execute_pipe.sv
// Execute stage: operand forwarding, single-cycle ALU and an iterative
// shift-add multiplier that stalls upstream while it runs.
module execute_pipe #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  logic [WIDTH-1:0] forwardM,
  input  logic [WIDTH-1:0] forwardWB,
  input  logic [1:0]       data1ForwardSelector,
  input  logic [1:0]       data2ForwardSelector,
  input  logic             data2Selector,
  input  logic [3:0]       aluControl,
  input  logic             inValid,
  output logic             stallE,
  output logic             outValid,
  output logic [WIDTH-1:0] aluOutput,
  output logic [WIDTH-1:0] data2AfterForward,
  output logic [3:0]       ALUFlagsE
);

  localparam int   CW     = $clog2(WIDTH + 1);
  localparam int   SW     = $clog2(WIDTH);
  localparam int   MSB    = WIDTH - 1;
  localparam logic MUL_ON = (MUL_EN != 0);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_PSB = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] d2_lat;
  logic [WIDTH-1:0] acc_next;

  logic [WIDTH-1:0] a_fwd;
  logic [WIDTH-1:0] b_fwd;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   sum;
  logic             alu_c;
  logic             alu_v;
  logic             is_mul;
  logic             accept_alu;
  logic             accept_mul;
  logic             finish_mul;

  // Operand forwarding muxes; select 11 falls back to the register file.
  always_comb begin
    a_fwd = data1;
    b_fwd = data2;
    case (data1ForwardSelector)
      2'b01:   a_fwd = forwardWB;
      2'b10:   a_fwd = forwardM;
      default: a_fwd = data1;
    endcase
    case (data2ForwardSelector)
      2'b01:   b_fwd = forwardWB;
      2'b10:   b_fwd = forwardM;
      default: b_fwd = data2;
    endcase
    if (data2Selector) begin
      alu_b = data3;
    end else begin
      alu_b = b_fwd;
    end
  end

  // Single-cycle ALU; MUL falls into the reserved branch here.
  always_comb begin
    alu_res = {WIDTH{1'b0}};
    sum     = {(WIDTH+1){1'b0}};
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (aluControl)
      OP_ADD: begin
        sum     = {1'b0, a_fwd} + {1'b0, alu_b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_fwd[MSB] == alu_b[MSB]) && (alu_res[MSB] != a_fwd[MSB]);
      end
      OP_SUB: begin
        // A + ~B + 1: carry out is the "no borrow" indication
        sum     = {1'b0, a_fwd} + {1'b0, ~alu_b} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_fwd[MSB] != alu_b[MSB]) && (alu_res[MSB] != a_fwd[MSB]);
      end
      OP_AND:  alu_res = a_fwd & alu_b;
      OP_OR:   alu_res = a_fwd | alu_b;
      OP_XOR:  alu_res = a_fwd ^ alu_b;
      OP_SHL:  alu_res = a_fwd << alu_b[SW-1:0];
      OP_SHR:  alu_res = a_fwd >> alu_b[SW-1:0];
      OP_PSB:  alu_res = alu_b;
      default: alu_res = {WIDTH{1'b0}};
    endcase
  end

  assign is_mul   = MUL_ON && (aluControl == OP_MUL);
  assign acc_next = acc + (mplier[0] ? mcand : {WIDTH{1'b0}});
  assign stallE   = (state == MUL);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next = state;
    accept_alu = 1'b0;
    accept_mul = 1'b0;
    finish_mul = 1'b0;
    case (state)
      IDLE: begin
        if (inValid && is_mul) begin
          accept_mul = 1'b1;
          state_next = MUL;
        end else if (inValid) begin
          accept_alu = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = IDLE;
        end
      end
      MUL: begin
        if (count == CW'(1)) begin
          finish_mul = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = MUL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Multiplier datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      count             <= {CW{1'b0}};
      acc               <= {WIDTH{1'b0}};
      mcand             <= {WIDTH{1'b0}};
      mplier            <= {WIDTH{1'b0}};
      d2_lat            <= {WIDTH{1'b0}};
      aluOutput         <= {WIDTH{1'b0}};
      data2AfterForward <= {WIDTH{1'b0}};
      ALUFlagsE         <= 4'b0000;
      outValid          <= 1'b0;
    end else begin
      outValid <= accept_alu || finish_mul;
      if (accept_alu) begin
        aluOutput         <= alu_res;
        ALUFlagsE         <= {alu_res[MSB], (alu_res == {WIDTH{1'b0}}), alu_c, alu_v};
        data2AfterForward <= b_fwd;
      end else if (finish_mul) begin
        aluOutput         <= acc_next;
        ALUFlagsE         <= {acc_next[MSB], (acc_next == {WIDTH{1'b0}}), 1'b0, 1'b0};
        data2AfterForward <= d2_lat;
      end
      if (accept_mul) begin
        mcand  <= a_fwd;
        mplier <= alu_b;
        acc    <= {WIDTH{1'b0}};
        count  <= CW'(WIDTH);
        d2_lat <= b_fwd;
      end else if (state == MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Randomised bench for execute_pipe (WIDTH=8) against an arithmetic reference
// model, plus directed corner cases and a MUL_EN=0 instance.
module tb_execute_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data1, data2, data3, forwardM, forwardWB;
  logic [1:0] data1ForwardSelector, data2ForwardSelector;
  logic       data2Selector;
  logic [3:0] aluControl;
  logic       inValid, in_valid_nm;
  logic       stallE, outValid, stall_nm, valid_nm;
  logic [7:0] aluOutput, data2AfterForward, res_nm, d2_nm;
  logic [3:0] ALUFlagsE, flags_nm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_pipe #(.WIDTH(8), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .data1(data1), .data2(data2), .data3(data3),
    .forwardM(forwardM), .forwardWB(forwardWB),
    .data1ForwardSelector(data1ForwardSelector),
    .data2ForwardSelector(data2ForwardSelector),
    .data2Selector(data2Selector), .aluControl(aluControl), .inValid(inValid),
    .stallE(stallE), .outValid(outValid), .aluOutput(aluOutput),
    .data2AfterForward(data2AfterForward), .ALUFlagsE(ALUFlagsE)
  );

  execute_pipe #(.WIDTH(8), .MUL_EN(0)) dut_nm (
    .clk(clk), .rst(rst), .data1(data1), .data2(data2), .data3(data3),
    .forwardM(forwardM), .forwardWB(forwardWB),
    .data1ForwardSelector(data1ForwardSelector),
    .data2ForwardSelector(data2ForwardSelector),
    .data2Selector(data2Selector), .aluControl(aluControl), .inValid(in_valid_nm),
    .stallE(stall_nm), .outValid(valid_nm), .aluOutput(res_nm),
    .data2AfterForward(d2_nm), .ALUFlagsE(flags_nm)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int fwd(input int sel, input int rf, input int wb, input int m);
    if (sel == 1) return wb;
    if (sel == 2) return m;
    return rf;
  endfunction

  function automatic int to_signed8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Returns {N,Z,C,V,result[7:0]} from plain integer arithmetic.
  function automatic logic [11:0] model(input int op, input int a, input int b, input bit mul_en);
    int r, s;
    bit c, v;
    logic [7:0] rr;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin r = a + b; c = (r > 255); s = to_signed8(a) + to_signed8(b); v = (s > 127) || (s < -128); end
      1: begin r = a - b; c = (a >= b);  s = to_signed8(a) - to_signed8(b); v = (s > 127) || (s < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a << (b % 8);
      6: r = a >> (b % 8);
      7: r = b;
      8: r = mul_en ? a * b : 0;
      default: r = 0;
    endcase
    r  = r & 255;
    rr = r[7:0];
    return {(r >= 128), (r == 0), c, v, rr};
  endfunction

  task automatic drive(input int op, input int s1, input int s2, input bit dsel,
                       input int d1, input int d2, input int d3, input int fm, input int fwb);
    aluControl           = 4'(op);
    data1ForwardSelector = 2'(s1);
    data2ForwardSelector = 2'(s2);
    data2Selector        = dsel;
    data1 = 8'(d1); data2 = 8'(d2); data3 = 8'(d3);
    forwardM = 8'(fm); forwardWB = 8'(fwb);
  endtask

  // Called #1 after a rising edge; leaves the bench #1 after the outValid edge.
  task automatic run_op(input string tag, input int op, input int s1, input int s2, input bit dsel,
                        input int d1, input int d2, input int d3, input int fm, input int fwb,
                        output logic [11:0] exp, output int bf);
    int a, bb, stalls;
    bit done;
    drive(op, s1, s2, dsel, d1, d2, d3, fm, fwb);
    a   = fwd(s1, d1, fwb, fm);
    bf  = fwd(s2, d2, fwb, fm);
    bb  = dsel ? d3 : bf;
    exp = model(op, a, bb, 1'b1);
    inValid = 1'b1;
    @(posedge clk); #1;
    if (op == 8) begin
      check({tag, "_accept"}, {30'd0, stallE, outValid}, 32'h2);
      stalls = 0;
      done   = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
        if (stallE) stalls++;
        drive(0, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), $urandom, $urandom,
              $urandom, $urandom, $urandom);
        inValid = 1'b1;
        @(posedge clk); #1;
        done = outValid;
      end
      check({tag, "_stall_cycles"}, stalls, 8);
      check({tag, "_done"}, {31'd0, done}, 32'h1);
      check({tag, "_stall_end"}, {31'd0, stallE}, 32'h0);
    end else begin
      check({tag, "_valid"}, {30'd0, stallE, outValid}, 32'h1);
    end
    check({tag, "_res"}, {24'd0, aluOutput}, {24'd0, exp[7:0]});
    check({tag, "_nzcv"}, {28'd0, ALUFlagsE}, {28'd0, exp[11:8]});
    check({tag, "_d2fwd"}, {24'd0, data2AfterForward}, 32'(bf));
    inValid = 1'b0;
  endtask

  task automatic idle_cycle(input string tag, input logic [11:0] exp);
    inValid = 1'b0;
    drive($urandom_range(0, 15), 0, 0, 1'b0, $urandom, $urandom, $urandom, $urandom, $urandom);
    @(posedge clk); #1;
    check({tag, "_no_valid"}, {31'd0, outValid}, 32'h0);
    check({tag, "_hold"}, {20'd0, ALUFlagsE, aluOutput}, {20'd0, exp});
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] e;
    int bf, op, cnt;
    rst = 1'b1;
    inValid = 1'b0;
    in_valid_nm = 1'b0;
    drive(0, 0, 0, 1'b0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {stallE, outValid, ALUFlagsE, aluOutput, data2AfterForward}, 32'h0);
    rst = 1'b0;

    run_op("add_ovf", 0, 0, 0, 1'b0, 8'h7F, 8'h01, 0, 0, 0, e, bf);
    check("add_ovf_const", {20'd0, ALUFlagsE, aluOutput}, 32'h980);
    run_op("sub_zero", 1, 0, 0, 1'b0, 5, 5, 0, 0, 0, e, bf);
    check("sub_zero_const", {20'd0, ALUFlagsE, aluOutput}, 32'h600);
    run_op("fwd_sub", 1, 2, 1, 1'b0, 8'hAA, 8'h55, 8'h01, 8'h10, 8'h03, e, bf);
    check("fwd_sub_const", {16'd0, aluOutput, data2AfterForward}, 32'h0D03);
    run_op("fwd_sub_imm", 1, 2, 1, 1'b1, 8'hAA, 8'h55, 8'h01, 8'h10, 8'h03, e, bf);
    check("fwd_sub_imm_const", {16'd0, aluOutput, data2AfterForward}, 32'h0F03);
    idle_cycle("idle1", e);
    run_op("mul_ff", 8, 0, 0, 1'b0, 8'h0F, 8'h11, 0, 0, 0, e, bf);
    check("mul_ff_const", {20'd0, ALUFlagsE, aluOutput}, 32'h8FF);
    run_op("rsv_f", 15, 0, 0, 1'b0, 8'h12, 8'h34, 0, 0, 0, e, bf);
    check("rsv_f_const", {20'd0, ALUFlagsE, aluOutput}, 32'h400);

    // MUL_EN=0 instance: opcode 1000 is reserved, single cycle, no stall.
    run_op("pre_nm", 0, 0, 0, 1'b0, 1, 1, 0, 0, 0, e, bf);
    drive(8, 0, 0, 1'b0, 8'h0F, 8'h11, 0, 0, 0);
    in_valid_nm = 1'b1;
    @(posedge clk); #1;
    in_valid_nm = 1'b0;
    check("nm_mul_valid", {30'd0, stall_nm, valid_nm}, 32'h1);
    check("nm_mul_res", {20'd0, flags_nm, res_nm}, 32'h400);
    check("nm_mul_d2", {24'd0, d2_nm}, 32'h11);

    // Reset during the third multiply cycle aborts without a result.
    run_op("pre_rst", 0, 0, 0, 1'b0, 8'h20, 8'h22, 0, 0, 0, e, bf);
    drive(8, 0, 0, 1'b0, 8'h0F, 8'h11, 0, 0, 0);
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid_busy", {31'd0, stallE}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_outs", {stallE, outValid, ALUFlagsE, aluOutput, data2AfterForward}, 32'h0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (outValid || stallE) cnt++;
    end
    check("rst_mid_quiet", cnt, 0);
    run_op("post_rst_add", 0, 0, 0, 1'b0, 2, 3, 0, 0, 0, e, bf);
    check("post_rst_add_const", {24'd0, aluOutput}, 32'h05);

    // Random back-to-back traffic with occasional idle cycles.
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 8 : $urandom_range(0, 15);
      run_op("rand", op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
             $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 255), e, bf);
      if ($urandom_range(0, 4) == 0) idle_cycle("rand_idle", e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 Parameter WIDTH, default 8, datapath width in bits (legal range 4..32).
REQ-002 Parameter MUL_EN, default 1; when 1 the iterative multiplier is present, when 0 the MUL opcode is treated as reserved.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 data1, data2  input  WIDTH  register-file operands A and B.
REQ-006 data3  input  WIDTH  immediate operand.
REQ-007 forwardM, forwardWB  input  WIDTH  forwarded values from the MEM and WB stages.
REQ-008 data1ForwardSelector, data2ForwardSelector  input  2  forwarding selects: 00 regfile, 01 forwardWB, 10 forwardM, 11 treated as 00.
REQ-009 data2Selector  input  1  0 selects forwarded B as the ALU B input; 1 selects data3.
REQ-010 aluControl  input  4  operation code (see REQ-015).
REQ-011 inValid  input  1  operation present on the inputs this cycle.
REQ-012 stallE  output  1  execute busy; upstream holds its inputs while this is high.
REQ-013 outValid  output  1  one-cycle pulse; the registered outputs hold a new result.
REQ-014 aluOutput (WIDTH), data2AfterForward (WIDTH), ALUFlagsE (4, {N,Z,C,V})  outputs  registered result, forwarded B (store data) and flags.

Function
REQ-015 Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SHL by B[log2(WIDTH)-1:0], 0110 logical SHR by the same amount, 0111 PASS B, 1000 MUL (low WIDTH bits of the product); all other codes are reserved and yield result 0 with flags Z=1, other flags 0.
REQ-016 All arithmetic is modulo 2^WIDTH.
REQ-017 N = result MSB and Z = (result == 0) for every opcode.
REQ-018 C and V for ADD: C is the carry out and V is signed overflow.
REQ-019 C and V for SUB (A-B): C=1 when no borrow occurs and V is signed overflow.
REQ-020 C and V for all other opcodes are 0.
REQ-021 FSM states are IDLE and MUL; reset state is IDLE.
REQ-022 In IDLE with inValid=1 and a non-MUL opcode, the edge registers aluOutput, flags and data2AfterForward, and outValid=1 for the following cycle only; latency is 1 and the state stays IDLE.
REQ-023 In IDLE with inValid=1 and opcode MUL (MUL_EN=1), the edge latches the forwarded A and final B, clears the accumulator, loads count=WIDTH and moves to MUL; outputs are unchanged.
REQ-024 In MUL, each edge performs one shift-add step and decrements count.
REQ-025 The edge at which count reaches 0 registers the product low bits, flags and latched data2AfterForward, asserts outValid for one cycle and returns to IDLE.
REQ-026 MUL latency is WIDTH+1 edges from the accept edge to outValid.
REQ-027 stallE = (state == MUL), combinational, so it is high for exactly WIDTH cycles.
REQ-028 inValid is ignored while in MUL; a new operation presented in the cycle outValid is high is accepted normally, allowing back-to-back operation.
REQ-029 data2AfterForward is always the forwarded B, independent of data2Selector.
REQ-030 When no result is produced, registered outputs hold their values and outValid=0.

Reset
REQ-031 rst=1 at an edge forces state IDLE, count 0, accumulator 0, aluOutput 0, data2AfterForward 0, ALUFlagsE 0000, outValid 0.
REQ-032 rst takes priority over every other input, including inValid.
REQ-033 rst asserted mid-MUL aborts the multiply with no outValid pulse; stallE is 0 in the cycle after the reset edge.

Verification (WIDTH=8)
REQ-034 ADD with A=0x7F, B=0x01 -> aluOutput 0x80, NZCV=1001, outValid on the next cycle.
REQ-035 SUB with A=0x05, B=0x05 -> aluOutput 0x00, NZCV=0110.
REQ-036 data1ForwardSelector=10 (forwardM=0x10), data2ForwardSelector=01 (forwardWB=0x03), SUB -> 0x0D; with data2Selector=1 and data3=0x01 -> 0x0F, and data2AfterForward=0x03 in both cases.
REQ-037 MUL 0x0F*0x11 -> stallE high for 8 cycles, then outValid with aluOutput 0xFF and NZCV=1000; a second ADD presented during the stall is ignored until IDLE.
REQ-038 MUL accepted, rst at the 3rd MUL cycle -> all outputs 0, no outValid, stallE 0 in the next cycle; a subsequent ADD 2+3 -> 0x05.
REQ-039 Reserved opcode 1111 -> aluOutput 0x00, NZCV=0100; with MUL_EN=0, opcode 1000 produces the same result and no stall.
